// File: rtl/dw_conv_rr_arbiter.sv
// Round-robin arbiter that locks one wide-stream requester onto a shared
// down-converter for a whole burst and rotates priority after each last beat.
module dw_conv_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_DW = 512,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NUM_REQ-1:0][DATA_DW-1:0]  req_data_i,
    input  logic [NUM_REQ-1:0]               req_valid_i,
    input  logic [NUM_REQ-1:0]               req_last_i,
    output logic [NUM_REQ-1:0]               req_ready_o,
    output logic [DATA_DW-1:0]               conv_data_o,
    output logic                             conv_valid_o,
    input  logic                             conv_ready_i,
    output logic [IDX_W-1:0]                 grant_idx_o,
    output logic                             busy_o
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] r_grant_q;
    logic             r_busy;

    logic             w_any_valid;
    logic [IDX_W-1:0] w_pick;
    logic [IDX_W-1:0] w_scan_sel;
    int               w_scan_idx;
    logic             w_handshake;
    logic [IDX_W-1:0] w_next_ptr;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        w_any_valid = 1'b0;
        w_pick      = '0;
        w_scan_idx  = 0;
        w_scan_sel  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_scan_idx = (int'(r_rr_ptr) + i) % NUM_REQ;
            w_scan_sel = IDX_W'(w_scan_idx);
            if (req_valid_i[w_scan_sel]) begin
                w_any_valid = 1'b1;
                w_pick      = w_scan_sel;
            end
        end
    end

    always_comb begin
        conv_valid_o = 1'b0;
        conv_data_o  = '0;
        req_ready_o  = '0;
        if (r_state == ST_GRANT) begin
            conv_valid_o           = req_valid_i[r_grant_q];
            conv_data_o            = req_data_i[r_grant_q];
            req_ready_o[r_grant_q] = conv_ready_i;
        end
    end

    assign w_handshake = conv_valid_o && conv_ready_i;
    assign w_next_ptr  = (r_grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant_q + 1'b1;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_rr_ptr  <= '0;
            r_grant_q <= '0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_valid) begin
                        r_grant_q <= w_pick;
                        r_state   <= ST_GRANT;
                        r_busy    <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (w_handshake && req_last_i[r_grant_q]) begin
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= ST_IDLE;
                        r_busy   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign grant_idx_o = r_grant_q;
    assign busy_o      = r_busy;

endmodule
